div_issue_ctrl: RTL and testbench

//  Initiator-side controller for the iterative radix-4 divider (start/done/busy interface).

---
 rtl/div_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Purpose: initiator-side issue controller for the iterative radix-4 divider (start/done/busy).
// Latency: request accept -> div_start next cycle; response one cycle after div_done (fast divide-by-zero path: next cycle).
// Backpressure: req_ready only in IDLE; response held stable until resp_ready; flush drops request/result.
// Optional feature macro: DIV_ZERO_FAST_EN (answer divide-by-zero locally without starting the divider).
module div_issue_ctrl #(
  parameter int DIV_WIDTH = 32,
  parameter int TAG_W     = 5,
  parameter int TIMEOUT   = 40
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_signed,
  input  logic [DIV_WIDTH-1:0] req_dividend,
  input  logic [DIV_WIDTH-1:0] req_divisor,
  input  logic [TAG_W-1:0]     req_tag,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DIV_WIDTH-1:0] resp_quotient,
  output logic [DIV_WIDTH-1:0] resp_remainder,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 div_start,
  output logic                 div_signed,
  output logic [DIV_WIDTH-1:0] div_dividend,
  output logic [DIV_WIDTH-1:0] div_divisor,
  input  logic                 div_busy,
  input  logic                 div_done,
  input  logic [DIV_WIDTH-1:0] div_quotient,
  input  logic [DIV_WIDTH-1:0] div_remainder,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic                   signed_q, signed_d;
  logic [DIV_WIDTH-1:0]   dividend_q, dividend_d;
  logic [DIV_WIDTH-1:0]   divisor_q, divisor_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [DIV_WIDTH-1:0]   quot_q, quot_d;
  logic [DIV_WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  // div_done is the only completion event we act on; the busy flag carries no extra information here.
  logic unused_div_busy;
  assign unused_div_busy = div_busy;

  // State register and held operands/results; reset clears everything including the sticky error.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= IDLE;
      signed_q   <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      tag_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      signed_q   <= signed_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      tag_q      <= tag_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept, launch, wait/drain with watchdog, and hold the response.
  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    tag_d      = tag_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          signed_d   = req_signed;
          dividend_d = req_dividend;
          divisor_d  = req_divisor;
          tag_d      = req_tag;
`ifdef DIV_ZERO_FAST_EN
          // Divide-by-zero has a fixed answer, so the divider is never started for it.
          if (req_divisor == '0) begin
            quot_d  = '1;
            rem_d   = req_dividend;
            state_d = RESP;
          end else begin
            state_d = LAUNCH;
          end
`else
          state_d = LAUNCH;
`endif
        end
      end
      LAUNCH: begin
        // The divider cannot be aborted, so a flush here still launches and then drains.
        cnt_d   = '0;
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (div_done) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            quot_d  = div_quotient;
            rem_d   = div_remainder;
            state_d = RESP;
          end
        end else if (flush) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (div_done) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        // One bubble after the handshake: IDLE is the only state that accepts.
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready      = (state_q == IDLE);
  assign div_start      = (state_q == LAUNCH);
  assign resp_valid     = (state_q == RESP);
  assign resp_quotient  = quot_q;
  assign resp_remainder = rem_q;
  assign resp_tag       = tag_q;
  assign div_signed     = signed_q;
  assign div_dividend   = dividend_q;
  assign div_divisor    = divisor_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed requests, a behavioural divider with programmable latency,
// and a scoreboard monitor that compares each accepted response against hand-computed values.
module tb_div_issue_ctrl;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int NEVER = 1000000;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_signed = 1'b0;
  logic [W-1:0]  req_dividend = '0, req_divisor = '0;
  logic [TW-1:0] req_tag = '0;
  logic          flush = 1'b0;
  logic          resp_valid, resp_ready = 1'b1;
  logic [W-1:0]  resp_quotient, resp_remainder;
  logic [TW-1:0] resp_tag;
  logic          div_start, div_signed;
  logic [W-1:0]  div_dividend, div_divisor;
  logic          div_busy = 1'b0, div_done = 1'b0;
  logic [W-1:0]  div_quotient = '0, div_remainder = '0;
  logic          err_timeout;

  always #5 cpu_clk = ~cpu_clk;

  div_issue_ctrl #(.DIV_WIDTH(W), .TAG_W(TW), .TIMEOUT(40)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_tag(resp_tag),
    .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .err_timeout(err_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
  } resp_t;
  resp_t sb_q[$];

  // Behavioural divider: done arrives div_lat cycles after the start cycle.
  int           div_lat = 1;
  int           busy_cnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_s = 1'b0;
  initial begin
    forever begin
      @(negedge cpu_clk);
      div_done      = 1'b0;
      div_quotient  = 32'hDEADBEEF;
      div_remainder = 32'hBADC0FFE;
      if (!cpu_rstn || req_ready) begin
        busy_cnt = 0;
      end else if (div_start) begin
        m_s = div_signed; m_a = div_dividend; m_b = div_divisor;
        busy_cnt = div_lat;
      end else if (busy_cnt > 0) begin
        chk("operand_hold", {div_signed, div_dividend, div_divisor}, {m_s, m_a, m_b});
        busy_cnt--;
        if (busy_cnt == 0) begin
          div_done = 1'b1;
          if (m_b == '0) begin
            div_quotient  = '1;
            div_remainder = m_a;
          end else if (m_s) begin
            div_quotient  = W'($signed(m_a) / $signed(m_b));
            div_remainder = W'($signed(m_a) % $signed(m_b));
          end else begin
            div_quotient  = m_a / m_b;
            div_remainder = m_a % m_b;
          end
        end
      end
      div_busy = (busy_cnt > 0);
    end
  end

  // Response monitor: stability while stalled, scoreboard compare on handshake.
  initial begin
    resp_t prev;
    resp_t exp;
    logic  stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge cpu_clk);
      if (cpu_rstn && resp_valid) begin
        if (stalled) chk("resp_stable", {resp_quotient, resp_remainder, resp_tag}, prev);
        if (resp_ready) begin
          if (sb_q.size() == 0) begin
            fail_now("unexpected_resp");
          end else begin
            exp = sb_q.pop_front();
            chk("resp_data", {resp_quotient, resp_remainder, resp_tag}, exp);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = {resp_quotient, resp_remainder, resp_tag};
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Present a request and return at accept edge + 1.
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t, input int lat);
    bit ok;
    ok = 1'b0;
    div_lat = lat;
    req_signed = s; req_dividend = a; req_divisor = b; req_tag = t;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge cpu_clk);
      ok = req_ready && !flush;
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: request tag %0d not accepted", t);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge cpu_clk);
      seen = req_ready;
    end
    chk({nm, "_idle"}, seen, 1'b1);
    step();
  endtask

  task automatic wait_resp(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge cpu_clk);
      seen = resp_valid;
    end
    chk({nm, "_resp_seen"}, seen, 1'b1);
  endtask

  // After a flush: no accept until div_done, then ready again with no response.
  task automatic drain_check(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge cpu_clk);
      seen = div_done;
      chk({nm, "_ready_low"}, {req_ready, resp_valid}, 2'b00);
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
    @(negedge cpu_clk);
    chk({nm, "_ready_after"}, {req_ready, resp_valid}, 2'b10);
    step();
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, {div_start, resp_valid, err_timeout, div_signed}, 4'b0000);
    chk({nm, "_ops"}, {div_dividend, div_divisor}, 64'd0);
    chk({nm, "_resp"}, {resp_quotient, resp_remainder, resp_tag}, 69'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk_reset_outs("reset");
    step(); step();
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    chk("reset_ready", req_ready, 1'b1);
    step();

    // 1: unsigned 100/7, start pulse exactly one cycle after accept
    sb_q.push_back('{q: 32'd14, r: 32'd2, tag: 5'd3});
    send(1'b0, 32'd100, 32'd7, 5'd3, 4);
    @(negedge cpu_clk);
    chk("t1_launch", {div_start, div_signed, div_dividend, div_divisor}, {1'b1, 1'b0, 32'd100, 32'd7});
    @(negedge cpu_clk);
    chk("t1_start_pulse_end", div_start, 1'b0);
    wait_idle("t1");

    // 2: signed -7/2
    sb_q.push_back('{q: 32'hFFFFFFFD, r: 32'hFFFFFFFF, tag: 5'd5});
    send(1'b1, 32'hFFFFFFF9, 32'd2, 5'd5, 2);
    @(negedge cpu_clk);
    chk("t2_signed", {div_start, div_signed}, 2'b11);
    wait_idle("t2");

    // 3: 3/10, fastest divider: done at T+2, resp_valid at T+3
    sb_q.push_back('{q: 32'd0, r: 32'd3, tag: 5'd17});
    send(1'b0, 32'd3, 32'd10, 5'd17, 1);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    chk("t3_t2", {div_done, resp_valid}, 2'b10);
    @(negedge cpu_clk);
    chk("t3_t3", resp_valid, 1'b1);
    wait_idle("t3");

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; flush = 1'b1; req_divisor = 32'd1;
    @(negedge cpu_clk);
    step();
    req_valid = 1'b0; flush = 1'b0;
    @(negedge cpu_clk);
    chk("idle_flush_no_accept", {div_start, req_ready}, 2'b01);
    step();

    // 4: FFFFFFFF/1 flushed in WAIT
    send(1'b0, 32'hFFFFFFFF, 32'd1, 5'd1, 6);
    @(negedge cpu_clk);
    step();
    flush = 1'b1;
    @(negedge cpu_clk);
    chk("t4_in_wait", {div_start, req_ready, resp_valid}, 3'b000);
    step();
    flush = 1'b0;
    drain_check("t4");

    // Flush in LAUNCH: still pulses start, then drains
    send(1'b0, 32'd40, 32'd6, 5'd2, 3);
    flush = 1'b1;
    @(negedge cpu_clk);
    chk("launch_flush_start", div_start, 1'b1);
    step();
    flush = 1'b0;
    drain_check("launch_flush");

    // Flush coincident with div_done: result dropped, straight to IDLE
    send(1'b0, 32'd50, 32'd5, 5'd8, 3);
    @(negedge cpu_clk); @(negedge cpu_clk); @(negedge cpu_clk);
    step();
    flush = 1'b1;
    @(negedge cpu_clk);
    chk("flush_done_same_done", div_done, 1'b1);
    step();
    flush = 1'b0;
    @(negedge cpu_clk);
    chk("flush_done_same_idle", {req_ready, resp_valid}, 2'b10);
    step();

    // 5: resp_ready low for 10 cycles, then handshake and one bubble
    resp_ready = 1'b0;
    sb_q.push_back('{q: 32'd14, r: 32'd2, tag: 5'd9});
    send(1'b0, 32'd100, 32'd7, 5'd9, 3);
    wait_resp("t5");
    for (int i = 0; i < 10; i++) begin
      @(negedge cpu_clk);
      chk("t5_hold_valid", {resp_valid, req_ready}, 2'b10);
    end
    step();
    resp_ready = 1'b1;
    @(negedge cpu_clk);
    chk("t5_bubble", req_ready, 1'b0);
    @(negedge cpu_clk);
    chk("t5_idle", {req_ready, resp_valid}, 2'b10);
    step();

    // Flush in RESP drops the response
    resp_ready = 1'b0;
    send(1'b0, 32'd20, 32'd4, 5'd7, 1);
    wait_resp("resp_flush");
    step();
    flush = 1'b1;
    @(negedge cpu_clk);
    chk("resp_flush_held", resp_valid, 1'b1);
    step();
    flush = 1'b0;
    resp_ready = 1'b1;
    @(negedge cpu_clk);
    chk("resp_flush_dropped", {resp_valid, req_ready}, 2'b01);
    step();

    // 6: divide by zero, 55/0
    sb_q.push_back('{q: 32'hFFFFFFFF, r: 32'd55, tag: 5'd2});
    send(1'b0, 32'd55, 32'd0, 5'd2, 2);
    @(negedge cpu_clk);
`ifdef DIV_ZERO_FAST_EN
    chk("div0_fast", {div_start, resp_valid}, 2'b01);
`else
    chk("div0_normal", {div_start, resp_valid}, 2'b10);
`endif
    wait_idle("div0");

    // Timeout: 40 WAIT cycles without div_done
    send(1'b0, 32'd1000, 32'd3, 5'd4, NEVER);
    repeat (41) @(negedge cpu_clk);
    chk("timeout_last_wait", {err_timeout, req_ready}, 2'b00);
    @(negedge cpu_clk);
    chk("timeout_fired", {err_timeout, req_ready}, 2'b11);
    step();
    step();
    chk("timeout_sticky", err_timeout, 1'b1);

    // Reset in the middle of an operation
    send(1'b1, 32'hFFFFFF00, 32'd5, 5'd6, NEVER);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk_reset_outs("midreset");
    step(); step();
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    chk("midreset_ready", {req_ready, err_timeout}, 2'b10);
    step();

    repeat (3) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
